alu_bist_driver: RTL and testbench
==================================

ALU_BIST_DRIVER -- requirements
Module: alu_bist_driver

Interface
REQ-001 Parameter NUM_VEC, default 16, vectors applied per funct code; legal range 4..255.
REQ-002 Parameter SEED, default 32'hACE12468, LFSR seed; non-zero.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to run one full test pass.
REQ-006 alu_out  input  32  result returned by the ALU under test.
REQ-007 zero  input  1  zero flag returned by the ALU under test.
REQ-008 data1  output  32  operand A driven to the ALU, registered.
REQ-009 data2  output  32  operand B driven to the ALU, registered.
REQ-010 funct  output  3  operation code driven to the ALU, registered.
REQ-011 busy  output  1  high while a test pass is running.
REQ-012 done  output  1  high from end of pass until next start or reset.
REQ-013 pass  output  1  high with done when err_count is 0.
REQ-014 err_count  output  8  mismatching vectors, saturating at 255.
REQ-015 fail_funct  output  3  funct of first mismatching vector.
REQ-016 fail_idx  output  8  vector index of first mismatching vector.

Function
REQ-017 FSM states: IDLE, DRIVE, SAMPLE, DONE; IDLE/DONE --start--> DRIVE; DRIVE -> SAMPLE; SAMPLE -> DRIVE for the next vector, or -> DONE after the last vector.
REQ-018 Vector order: funct 000 to 111 ascending; per funct, index 0 to NUM_VEC-1.
REQ-019 Indices 0-3 are directed (data1,data2): (0,0), (FFFFFFFF,1), (7FFFFFFF,7FFFFFFF), (80000000,FFFFFFFF).
REQ-020 Index >=4: data1 = LFSR state; data2 = LFSR state rotated left 16, XOR 32'h5A5A5A5A; LFSR advances once per random vector.
REQ-021 LFSR: 32-bit Fibonacci, taps 32,22,2,1; loaded with SEED on every accepted start.
REQ-022 Operands and funct update on entry to DRIVE and hold through SAMPLE; the ALU is combinational, and alu_out/zero are compared in SAMPLE.
REQ-023 Expected model: 000 AND, 001 OR, 010 ADD mod 2^32, 011 XOR, 100 NOR, 101 SLTU, 110 SUB mod 2^32, 111 SLT signed.
REQ-024 SLT/SLTU results are 32'h1 or 32'h0.
REQ-025 Expected zero is 1 iff the expected result is 32'h0.
REQ-026 Mismatch is an alu_out difference OR a zero difference; each mismatching vector counts once.
REQ-027 err_count increments per mismatch and saturates at 255, with no wrap.
REQ-028 fail_funct/fail_idx capture only the first mismatch of a pass and hold otherwise.
REQ-029 Latency: start accepted in cycle t; done and pass valid in cycle t+1+16*NUM_VEC.
REQ-030 start is ignored while busy.
REQ-031 start in DONE clears err_count, fail_funct, fail_idx, done and pass, and begins a new pass.
REQ-032 busy = 1 in DRIVE and SAMPLE only.
REQ-033 done = 1 in DONE only.

Reset
REQ-034 rst forces IDLE on the next edge, including mid-pass.
REQ-035 On rst: data1, data2, funct, busy, done, pass, err_count, fail_funct and fail_idx are all 0.
REQ-036 On rst the LFSR loads SEED.
REQ-037 rst has priority over start in the same cycle.

Verification
REQ-038 NUM_VEC=4, golden ALU, start pulse at t -> done=1, pass=1 and err_count=0 at t+65; busy=1 from t+1 to t+64.
REQ-039 ALU with ADD replaced by OR -> first failure at (FFFFFFFF,1) -> fail_funct=010, fail_idx=1, pass=0.
REQ-040 ALU zero stuck at 0 -> first failure on AND (0,0) -> fail_funct=000, fail_idx=0, err_count>0.
REQ-041 NUM_VEC=64, alu_out = ~expected -> err_count=255 at done, with no wrap.
REQ-042 rst asserted in DRIVE mid-pass -> all outputs 0 next cycle; a new start re-runs from funct 000, index 0, LFSR=SEED, and gives an identical result.
REQ-043 start pulsed while busy -> no restart, done still at t+1+16*NUM_VEC; start pulsed in DONE -> done drops and a new pass begins.

Source files
------------

// File: rtl/alu_bist_driver.sv
// Built-in self-test sequencer for a combinational 32-bit ALU: drives directed and
// LFSR operand pairs for every funct code, checks each result, and reports the first failure.
module alu_bist_driver #(
    parameter int          NUM_VEC = 16,
    parameter logic [31:0] SEED    = 32'hACE12468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] alu_out,
    input  logic        zero,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [2:0]  funct,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [2:0]  fail_funct,
    output logic [7:0]  fail_idx
);

    localparam int                DATA_W   = 32;
    localparam logic [7:0]        LAST_IDX = 8'(NUM_VEC - 1);
    localparam logic [DATA_W-1:0] MIX      = 32'h5A5A5A5A;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] lfsr;
    logic [7:0]        idx;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [DATA_W-1:0] alu_expect(input logic [2:0]        f,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic        [DATA_W-1:0] r;
        sa = a;
        sb = b;
        case (f)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b011:  r = a ^ b;
            3'b100:  r = ~(a | b);
            3'b101:  r = (a < b) ? 32'd1 : 32'd0;
            3'b110:  r = a - b;
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [DATA_W-1:0] exp_res;
    logic [DATA_W-1:0] vec_a;
    logic [DATA_W-1:0] vec_b;
    logic              mismatch;
    logic              idx_wrap;
    logic              last_vec;
    logic              rand_vec;
    logic [7:0]        err_next;
    logic [7:0]        nxt_idx;
    logic [7:0]        sel_idx;
    logic [2:0]        nxt_funct;

    always_comb begin
        exp_res   = alu_expect(funct, data1, data2);
        mismatch  = (alu_out != exp_res) || (zero != (exp_res == '0));
        err_next  = mismatch ? sat_inc(err_count) : err_count;
        idx_wrap  = (idx == LAST_IDX);
        last_vec  = idx_wrap && (funct == 3'b111);
        nxt_idx   = idx_wrap ? 8'd0 : idx + 8'd1;
        nxt_funct = idx_wrap ? funct + 3'd1 : funct;
        // Index of the vector loaded on the next entry to DRIVE (index 0 when a pass starts)
        sel_idx   = (state == SAMPLE) ? nxt_idx : 8'd0;
        rand_vec  = (sel_idx >= 8'd4);
        case (sel_idx)
            8'd0: begin
                vec_a = 32'h00000000;
                vec_b = 32'h00000000;
            end
            8'd1: begin
                vec_a = 32'hFFFFFFFF;
                vec_b = 32'h00000001;
            end
            8'd2: begin
                vec_a = 32'h7FFFFFFF;
                vec_b = 32'h7FFFFFFF;
            end
            8'd3: begin
                vec_a = 32'h80000000;
                vec_b = 32'hFFFFFFFF;
            end
            default: begin
                vec_a = lfsr;
                vec_b = {lfsr[15:0], lfsr[31:16]} ^ MIX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            idx        <= 8'd0;
            data1      <= '0;
            data2      <= '0;
            funct      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            fail_funct <= 3'd0;
            fail_idx   <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        lfsr       <= SEED;
                        idx        <= 8'd0;
                        funct      <= 3'd0;
                        data1      <= vec_a;
                        data2      <= vec_b;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 8'd0;
                        fail_funct <= 3'd0;
                        fail_idx   <= 8'd0;
                    end
                end
                DRIVE: state <= SAMPLE;
                SAMPLE: begin
                    err_count <= err_next;
                    // err_count never returns to zero within a pass, so zero marks "no failure yet"
                    if (mismatch && (err_count == 8'd0)) begin
                        fail_funct <= funct;
                        fail_idx   <= idx;
                    end
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                    end else begin
                        state <= DRIVE;
                        idx   <= nxt_idx;
                        funct <= nxt_funct;
                        data1 <= vec_a;
                        data2 <= vec_b;
                        if (rand_vec) begin
                            lfsr <= lfsr_step(lfsr);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: two instances (4 and 64 vectors per funct) driving a faultable
// ALU model, with a per-cycle timeline model and literal pins on the key scenarios.
module tb_alu_bist_driver;

    localparam int          NV_A = 4;
    localparam int          NV_B = 64;
    localparam logic [31:0] SEED = 32'hACE12468;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        start     [2];
    logic [31:0] alu_out   [2];
    logic        zero      [2];
    logic [31:0] d1        [2];
    logic [31:0] d2        [2];
    logic [2:0]  fn        [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic [7:0]  ec        [2];
    logic [2:0]  ff        [2];
    logic [7:0]  fi        [2];

    int mode [2] = '{0, 0};
    int nv   [2] = '{NV_A, NV_B};

    logic [31:0] va [2][512];
    logic [31:0] vb [2][512];
    logic [2:0]  vf [2][512];

    logic [7:0] p_err  [2];
    logic [2:0] p_ff   [2];
    logic [7:0] p_fi   [2];
    logic       p_pass [2];
    logic [7:0] q_err  [2];
    logic [2:0] q_ff   [2];
    logic [7:0] q_fi   [2];
    logic       q_pass [2];

    int cyc       = 0;
    int t0    [2] = '{0, 0};
    bit m_run [2] = '{1'b0, 1'b0};
    bit chk_en    = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_bist_driver #(.NUM_VEC(NV_A), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .alu_out(alu_out[0]), .zero(zero[0]),
        .data1(d1[0]), .data2(d2[0]), .funct(fn[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(ec[0]), .fail_funct(ff[0]), .fail_idx(fi[0])
    );

    alu_bist_driver #(.NUM_VEC(NV_B), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .alu_out(alu_out[1]), .zero(zero[1]),
        .data1(d1[1]), .data2(d2[1]), .funct(fn[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(ec[1]), .fail_funct(ff[1]), .fail_idx(fi[1])
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a | b);
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            3'd6:    return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // ALU under test: 0 golden, 1 ADD built as OR, 2 zero flag stuck low, 3 inverted result
    function automatic logic [32:0] dut_alu(input int m, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        z;
        r = ref_alu(f, a, b);
        z = (r == 32'd0);
        if (m == 1 && f == 3'd2) begin
            r = a | b;
            z = (r == 32'd0);
        end
        if (m == 2) z = 1'b0;
        if (m == 3) r = ~r;
        return {z, r};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) {zero[i], alu_out[i]} = dut_alu(mode[i], fn[i], d1[i], d2[i]);
    end

    function automatic void build(input int id);
        logic [31:0] s;
        int          i;
        s = SEED;
        for (int k = 0; k < 8 * nv[id]; k++) begin
            i = k % nv[id];
            vf[id][k] = 3'(k / nv[id]);
            case (i)
                0: begin va[id][k] = 32'h00000000; vb[id][k] = 32'h00000000; end
                1: begin va[id][k] = 32'hFFFFFFFF; vb[id][k] = 32'h00000001; end
                2: begin va[id][k] = 32'h7FFFFFFF; vb[id][k] = 32'h7FFFFFFF; end
                3: begin va[id][k] = 32'h80000000; vb[id][k] = 32'hFFFFFFFF; end
                default: begin
                    va[id][k] = s;
                    vb[id][k] = {s[15:0], s[31:16]} ^ 32'h5A5A5A5A;
                    s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
                end
            endcase
        end
    endfunction

    function automatic void predict(input int id);
        int          cnt;
        logic [31:0] r;
        logic [32:0] got;
        cnt = 0;
        p_ff[id] = 3'd0;
        p_fi[id] = 8'd0;
        for (int k = 0; k < 8 * nv[id]; k++) begin
            r   = ref_alu(vf[id][k], va[id][k], vb[id][k]);
            got = dut_alu(mode[id], vf[id][k], va[id][k], vb[id][k]);
            if (got != {(r == 32'd0), r}) begin
                if (cnt == 0) begin
                    p_ff[id] = vf[id][k];
                    p_fi[id] = 8'(k % nv[id]);
                end
                if (cnt < 255) cnt++;
            end
        end
        p_err[id]  = 8'(cnt);
        p_pass[id] = (cnt == 0);
    endfunction

    function automatic bit busy_at(input int id, input int c);
        return m_run[id] && (c - t0[id] >= 1) && (c - t0[id] <= 16 * nv[id]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timeline: which pass is running and when it started
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int id = 0; id < 2; id++) begin
            if (rst[id]) begin
                m_run[id] <= 1'b0;
            end else if (start[id] && !busy_at(id, cyc)) begin
                m_run[id]  <= 1'b1;
                t0[id]     <= cyc;
                q_err[id]  <= p_err[id];
                q_ff[id]   <= p_ff[id];
                q_fi[id]   <= p_fi[id];
                q_pass[id] <= p_pass[id];
            end
        end
    end

    task automatic check_cycle(input int id);
        int    d;
        int    k;
        string p;
        p = (id == 0) ? "A" : "B";
        if (!m_run[id]) begin
            chk({p, " idle data1"}, d1[id], 32'd0);
            chk({p, " idle data2"}, d2[id], 32'd0);
            chk({p, " idle funct"}, 32'(fn[id]), 32'd0);
            chk({p, " idle busy"}, 32'(busy[id]), 32'd0);
            chk({p, " idle done"}, 32'(done[id]), 32'd0);
            chk({p, " idle pass"}, 32'(pass[id]), 32'd0);
            chk({p, " idle err_count"}, 32'(ec[id]), 32'd0);
            chk({p, " idle fail_funct"}, 32'(ff[id]), 32'd0);
            chk({p, " idle fail_idx"}, 32'(fi[id]), 32'd0);
        end else begin
            d = cyc - t0[id];
            if (d <= 16 * nv[id]) begin
                k = (d - 1) / 2;
                chk({p, " run busy"}, 32'(busy[id]), 32'd1);
                chk({p, " run done"}, 32'(done[id]), 32'd0);
                chk({p, " run data1"}, d1[id], va[id][k]);
                chk({p, " run data2"}, d2[id], vb[id][k]);
                chk({p, " run funct"}, 32'(fn[id]), 32'(vf[id][k]));
                if (d == 1) begin
                    chk({p, " start err_count"}, 32'(ec[id]), 32'd0);
                    chk({p, " start pass"}, 32'(pass[id]), 32'd0);
                    chk({p, " start fail_funct"}, 32'(ff[id]), 32'd0);
                    chk({p, " start fail_idx"}, 32'(fi[id]), 32'd0);
                end
            end else begin
                chk({p, " done busy"}, 32'(busy[id]), 32'd0);
                chk({p, " done done"}, 32'(done[id]), 32'd1);
                chk({p, " done pass"}, 32'(pass[id]), 32'(q_pass[id]));
                chk({p, " done err_count"}, 32'(ec[id]), 32'(q_err[id]));
                chk({p, " done fail_funct"}, 32'(ff[id]), 32'(q_ff[id]));
                chk({p, " done fail_idx"}, 32'(fi[id]), 32'(q_fi[id]));
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int id = 0; id < 2; id++) check_cycle(id);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first DRIVE cycle of the new pass
    task automatic launch(input int id, input int m);
        mode[id] = m;
        predict(id);
        start[id] = 1'b1;
        step();
        start[id] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_at;
        rst[0] = 1'b1; rst[1] = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        build(0);
        build(1);
        step();
        chk_en = 1'b1;
        step();
        step();
        chk("reset busy", 32'(busy[0]), 32'd0);
        chk("reset err_count", 32'(ec[0]), 32'd0);
        chk("reset data1", d1[1], 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();

        // Golden pass, NUM_VEC=4: busy t+1..t+64, done/pass at t+65
        launch(0, 0);
        chk("A busy t+1", 32'(busy[0]), 32'd1);
        repeat (63) step();
        chk("A busy t+64", 32'(busy[0]), 32'd1);
        chk("A done t+64", 32'(done[0]), 32'd0);
        step();
        chk("A done t+65", 32'(done[0]), 32'd1);
        chk("A pass t+65", 32'(pass[0]), 32'd1);
        chk("A err t+65", 32'(ec[0]), 32'd0);
        chk("A busy t+65", 32'(busy[0]), 32'd0);

        // ADD built as OR, with a start ignored mid-pass
        launch(0, 1);
        repeat (9) step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (54) step();
        chk("A add-or done", 32'(done[0]), 32'd1);
        chk("A add-or fail_funct", 32'(ff[0]), 32'd2);
        chk("A add-or fail_idx", 32'(fi[0]), 32'd1);
        chk("A add-or pass", 32'(pass[0]), 32'd0);

        // Restart from DONE with zero flag stuck low
        launch(0, 2);
        chk("A restart done drops", 32'(done[0]), 32'd0);
        chk("A restart busy", 32'(busy[0]), 32'd1);
        repeat (64) step();
        chk("A zero-stuck fail_funct", 32'(ff[0]), 32'd0);
        chk("A zero-stuck fail_idx", 32'(fi[0]), 32'd0);
        chk("A zero-stuck err>0", 32'(ec[0] != 8'd0), 32'd1);

        // Reset in DRIVE mid-pass, reset beating start, then an identical re-run
        launch(0, 0);
        repeat (20) step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("A midrst busy", 32'(busy[0]), 32'd0);
        chk("A midrst data1", d1[0], 32'd0);
        chk("A midrst funct", 32'(fn[0]), 32'd0);
        rst[0] = 1'b1;
        start[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        start[0] = 1'b0;
        chk("A rst over start", 32'(busy[0]), 32'd0);
        launch(0, 0);
        repeat (64) step();
        chk("A rerun pass", 32'(pass[0]), 32'd1);
        chk("A rerun done", 32'(done[0]), 32'd1);

        // Randomized episodes: fault mode, stray starts, occasional reset
        for (int ep = 0; ep < 12; ep++) begin
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 63)) : 0;
            launch(0, int'($urandom_range(0, 3)));
            for (int d = 1; d < 65; d++) begin
                if (d == rst_at) begin
                    rst[0] = 1'b1;
                    step();
                    rst[0] = 1'b0;
                    break;
                end
                start[0] = ($urandom_range(0, 7) == 0);
                step();
                start[0] = 1'b0;
            end
            repeat ($urandom_range(1, 4)) step();
        end

        // NUM_VEC=64: first LFSR vector, then saturation with an inverted ALU
        launch(1, 3);
        repeat (8) step();
        chk("B first random data1", d1[1], 32'hACE12468);
        chk("B first random data2", d2[1], 32'h7E32F6BB);
        chk("B first random funct", 32'(fn[1]), 32'd0);
        repeat (1016) step();
        chk("B sat done", 32'(done[1]), 32'd1);
        chk("B sat err_count", 32'(ec[1]), 32'd255);
        chk("B sat pass", 32'(pass[1]), 32'd0);
        launch(1, 0);
        repeat (1024) step();
        chk("B golden pass", 32'(pass[1]), 32'd1);
        chk("B golden err", 32'(ec[1]), 32'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
